display_mode_ctrl: RTL and testbench
====================================

Name: display_mode_ctrl

Overview:
Parametrised successor to the bike-computer display controller. It cycles through NUM_MODES display modes on debounced mode presses and blinks the mode annunciators on overspeed. It sequences the shared divider (speed, then average speed) with a pending-request buffer, and runs a start/valid handshake with a timeout against the ASCII encoder. It sits between the timebase, speed/avg-speed/divider modules and the ASCII encoder feeding the LCD driver.

Parameters:
NUM_MODES, 4, number of display modes (2..8); mode 0 is the reset mode
SPEED_WIDTH, 12, width of the speed bus
OVERSPEED, 65, speed strictly above this value triggers blinking
BLINK_DIV, 1, half_sec_pulse events per blink phase toggle (1..15)
TIM_MODE, 2, mode index whose colon toggles each second
POINT_MASK, 4'b0011, bit i set means the decimal point is lit in mode i
ENC_TIMEOUT, 16, clock cycles to wait for enc_valid before aborting (2..255)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
mode_btn  in  1  synchronised, debounced mode button (level)
half_sec_pulse  in  1  1-cycle strobe every 0.5 s
sec_pulse  in  1  1-cycle strobe every 1 s
speed  in  SPEED_WIDTH  live speed for the overspeed compare
speed_valid  in  1  speed module result ready (1 cycle)
avg_speed_valid  in  1  avg-speed module result ready (1 cycle)
speed_start  out  1  1-cycle start to speed module
avg_speed_start  out  1  1-cycle start to avg-speed module
div_select  out  1  divider mux: 1 = speed, 0 = avg speed
mode_idx  out  3  current mode index
mode_lamp  out  NUM_MODES  annunciator drive (includes blink)
enc_start  out  1  1-cycle start to encoder
enc_mode  out  NUM_MODES  one-hot mode sent to encoder (no blink), stable while waiting
enc_valid  in  1  encoder result ready (1 cycle)
enc_data  in  48  six ASCII characters from the encoder
disp_data  out  48  registered display characters
col  out  1  colon segment
point  out  1  decimal point segment
enc_err  out  1  sticky; set on encoder timeout
overrun_cnt  out  8  saturating count of dropped divider requests

Behaviour:
- Reset (reset=0, asynchronous) forces: mode_idx=0, all outputs 0 except div_select=1, mode_lamp=1, enc_mode=1. It also clears the blink phase, blink counter, pending flags and both FSMs to IDLE.
- Mode: rising edge of mode_btn (registered previous value) gives mode_pulse. mode_idx increments, and wraps NUM_MODES-1 -> 0. Holding the button advances exactly once.
- Blink: a counter counts half_sec_pulse events; at BLINK_DIV events the phase toggles and the counter clears. It runs regardless of speed.
- Lamps: mode_lamp = onehot(mode_idx). When speed > OVERSPEED and phase=1, mode_lamp = all ones. The compare is unsigned and a speed equal to OVERSPEED does not blink.
- Divider FSM has states D_IDLE, D_SPD and D_AVG.
  - D_IDLE: on sec_pulse or pend_div, pulse speed_start, set div_select=1, clear pend_div, go to D_SPD.
  - D_SPD: on speed_valid, pulse avg_speed_start the next cycle, set div_select=0, go to D_AVG.
  - D_AVG: on avg_speed_valid, set div_select=1 and go to D_IDLE.
  - sec_pulse while not in D_IDLE sets pend_div. If pend_div is already set, overrun_cnt increments, saturating at 255.
  - speed_valid outside D_SPD and avg_speed_valid outside D_AVG are ignored.
- Refresh FSM has states R_IDLE and R_WAIT.
  - A request is sec_pulse or mode_pulse.
  - R_IDLE: on a request or pend_ref, the next cycle gives enc_start=1, enc_mode=onehot(mode_idx), timer cleared, then R_WAIT.
  - R_WAIT, on enc_valid: disp_data <= enc_data, go to R_IDLE.
  - R_WAIT, on timer = ENC_TIMEOUT-1: set enc_err, keep disp_data, go to R_IDLE.
  - A request in R_WAIT sets pend_ref (depth 1, extras merge).
  - enc_valid in R_IDLE is ignored.
  - enc_valid in the same cycle as timeout counts as valid; data is captured and enc_err is not set.
- Segments: on each refresh start, point <= POINT_MASK[mode_idx].
  - col toggles on sec_pulse when mode_idx == TIM_MODE, and is 0 in other modes.
  - A mode change clears col in the same cycle as the index update.
- Simultaneous events:
  - sec_pulse and mode_pulse in the same cycle produce one refresh using the new mode_idx.
  - sec_pulse in the cycle D_AVG completes sets pend_div; it is not an overrun.

Test Plan:
- Reset release, 4 mode presses of 3 cycles each -> mode_idx 1,2,3,0; mode_lamp 0010, 0100, 1000, 0001; one enc_start per press.
- speed=66, BLINK_DIV=1, 4 half_sec_pulse -> mode_lamp alternates 1111/0001; speed=65 -> mode_lamp stays 0001.
- sec_pulse, speed_valid after 20 cycles, avg_speed_valid after 20 more -> speed_start at t+1, avg_speed_start the cycle after speed_valid, div_select 1->0->1.
- Three sec_pulse while in D_SPD -> pend_div set, overrun_cnt=2, exactly one extra speed_start after return to idle.
- enc_valid withheld for 16 cycles -> enc_err=1, disp_data unchanged; next sec_pulse with enc_valid at 5 cycles -> disp_data=enc_data ("012.34").
- Mode index TIM_MODE with 3 sec_pulse -> col 1,0,1; a mode press -> col=0; assert reset mid-R_WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/display_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_mode_ctrl
// Brief    : Display mode cycling, overspeed blink, divider sequencing and
//            encoder refresh handshake for the bike-computer LCD path.
// Revision : 1.0 - initial release
// ============================================================================
module display_mode_ctrl #(
  parameter int                   NUM_MODES   = 4,
  parameter int                   SPEED_WIDTH = 12,
  parameter int                   OVERSPEED   = 65,
  parameter int                   BLINK_DIV   = 1,
  parameter int                   TIM_MODE    = 2,
  parameter logic [NUM_MODES-1:0] POINT_MASK  = 4'b0011,
  parameter int                   ENC_TIMEOUT = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mode_btn,
  input  logic                   half_sec_pulse,
  input  logic                   sec_pulse,
  input  logic [SPEED_WIDTH-1:0] speed,
  input  logic                   speed_valid,
  input  logic                   avg_speed_valid,
  output logic                   speed_start,
  output logic                   avg_speed_start,
  output logic                   div_select,
  output logic [2:0]             mode_idx,
  output logic [NUM_MODES-1:0]   mode_lamp,
  output logic                   enc_start,
  output logic [NUM_MODES-1:0]   enc_mode,
  input  logic                   enc_valid,
  input  logic [47:0]            enc_data,
  output logic [47:0]            disp_data,
  output logic                   col,
  output logic                   point,
  output logic                   enc_err,
  output logic [7:0]             overrun_cnt
);

  localparam logic [2:0]             c_last_mode    = 3'(NUM_MODES - 1);
  localparam logic [2:0]             c_tim_mode     = 3'(TIM_MODE);
  localparam logic [3:0]             c_blink_last   = 4'(BLINK_DIV - 1);
  localparam logic [7:0]             c_timeout_last = 8'(ENC_TIMEOUT - 1);
  localparam logic [SPEED_WIDTH-1:0] c_overspeed    = SPEED_WIDTH'(OVERSPEED);

  typedef enum logic [1:0] {D_IDLE = 2'd0, D_SPD = 2'd1, D_AVG = 2'd2} div_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_WAIT = 1'b1} ref_state_t;

  function automatic logic [NUM_MODES-1:0] f_onehot(input logic [2:0] idx);
    for (int i = 0; i < NUM_MODES; i++) begin
      f_onehot[i] = (idx == 3'(i));
    end
  endfunction

  // Mode selection
  logic                 r_btn_prev;
  logic [2:0]           r_mode_idx;
  logic                 w_mode_pulse;
  logic [2:0]           w_mode_nxt;
  logic [NUM_MODES-1:0] w_onehot_nxt;

  assign w_mode_pulse = mode_btn & ~r_btn_prev;
  assign w_onehot_nxt = f_onehot(w_mode_nxt);

  always_comb begin
    w_mode_nxt = r_mode_idx;
    if (w_mode_pulse) begin
      w_mode_nxt = (r_mode_idx == c_last_mode) ? 3'd0 : r_mode_idx + 3'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_btn_prev <= 1'b0;
      r_mode_idx <= 3'd0;
    end else begin
      r_btn_prev <= mode_btn;
      r_mode_idx <= w_mode_nxt;
    end
  end

  // Blink phase generator
  logic [3:0] r_blink_cnt;
  logic       r_phase;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_blink_cnt <= 4'd0;
      r_phase     <= 1'b0;
    end else if (half_sec_pulse) begin
      if (r_blink_cnt >= c_blink_last) begin
        r_blink_cnt <= 4'd0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 4'd1;
      end
    end
  end

  logic w_overspeed;
  assign w_overspeed = (speed > c_overspeed);
  assign mode_lamp   = (w_overspeed && r_phase) ? {NUM_MODES{1'b1}} : f_onehot(r_mode_idx);

  // Divider sequencer
  div_state_t r_d_state, w_d_state_nxt;
  logic       r_speed_start, w_speed_start_nxt;
  logic       r_avg_start, w_avg_start_nxt;
  logic       r_div_select, w_div_select_nxt;
  logic       r_pend_div, w_pend_div_nxt;
  logic       w_ovr_inc;
  logic [7:0] r_overrun;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_d_state <= D_IDLE;
    end else begin
      r_d_state <= w_d_state_nxt;
    end
  end

  always_comb begin
    w_d_state_nxt     = r_d_state;
    w_speed_start_nxt = 1'b0;
    w_avg_start_nxt   = 1'b0;
    w_div_select_nxt  = r_div_select;
    w_pend_div_nxt    = r_pend_div;
    w_ovr_inc         = 1'b0;
    case (r_d_state)
      D_IDLE: begin
        if (sec_pulse || r_pend_div) begin
          w_speed_start_nxt = 1'b1;
          w_div_select_nxt  = 1'b1;
          w_pend_div_nxt    = 1'b0;
          w_d_state_nxt     = D_SPD;
        end
      end
      D_SPD: begin
        if (speed_valid) begin
          w_avg_start_nxt  = 1'b1;
          w_div_select_nxt = 1'b0;
          w_d_state_nxt    = D_AVG;
        end
      end
      D_AVG: begin
        if (avg_speed_valid) begin
          w_div_select_nxt = 1'b1;
          w_d_state_nxt    = D_IDLE;
        end
      end
      default: w_d_state_nxt = D_IDLE;
    endcase
    // A second request while one is already queued is dropped and counted
    if (sec_pulse && (r_d_state != D_IDLE)) begin
      if (r_pend_div) begin
        w_ovr_inc = 1'b1;
      end else begin
        w_pend_div_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_speed_start <= 1'b0;
      r_avg_start   <= 1'b0;
      r_div_select  <= 1'b1;
      r_pend_div    <= 1'b0;
      r_overrun     <= 8'd0;
    end else begin
      r_speed_start <= w_speed_start_nxt;
      r_avg_start   <= w_avg_start_nxt;
      r_div_select  <= w_div_select_nxt;
      r_pend_div    <= w_pend_div_nxt;
      if (w_ovr_inc && (r_overrun != 8'hFF)) begin
        r_overrun <= r_overrun + 8'd1;
      end
    end
  end

  // Encoder refresh handshake
  ref_state_t           r_r_state, w_r_state_nxt;
  logic                 w_ref_req;
  logic                 r_pend_ref, w_pend_ref_nxt;
  logic                 w_enc_start_nxt;
  logic                 w_capture;
  logic                 w_timeout;
  logic [7:0]           r_timer;
  logic                 r_enc_start;
  logic [NUM_MODES-1:0] r_enc_mode;
  logic [47:0]          r_disp;
  logic                 r_enc_err;
  logic                 r_point;
  logic                 r_col;

  assign w_ref_req = sec_pulse | w_mode_pulse;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_r_state <= R_IDLE;
    end else begin
      r_r_state <= w_r_state_nxt;
    end
  end

  always_comb begin
    w_r_state_nxt   = r_r_state;
    w_pend_ref_nxt  = r_pend_ref;
    w_enc_start_nxt = 1'b0;
    w_capture       = 1'b0;
    w_timeout       = 1'b0;
    case (r_r_state)
      R_IDLE: begin
        if (w_ref_req || r_pend_ref) begin
          w_enc_start_nxt = 1'b1;
          w_pend_ref_nxt  = 1'b0;
          w_r_state_nxt   = R_WAIT;
        end
      end
      R_WAIT: begin
        if (w_ref_req) begin
          w_pend_ref_nxt = 1'b1;
        end
        // Valid data wins over a timeout landing in the same cycle
        if (enc_valid) begin
          w_capture     = 1'b1;
          w_r_state_nxt = R_IDLE;
        end else if (r_timer == c_timeout_last) begin
          w_timeout     = 1'b1;
          w_r_state_nxt = R_IDLE;
        end
      end
      default: w_r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend_ref  <= 1'b0;
      r_enc_start <= 1'b0;
      r_timer     <= 8'd0;
      r_enc_mode  <= f_onehot(3'd0);
      r_disp      <= 48'd0;
      r_enc_err   <= 1'b0;
      r_point     <= 1'b0;
    end else begin
      r_pend_ref  <= w_pend_ref_nxt;
      r_enc_start <= w_enc_start_nxt;
      if (w_enc_start_nxt) begin
        r_timer    <= 8'd0;
        r_enc_mode <= w_onehot_nxt;
        r_point    <= |(w_onehot_nxt & POINT_MASK);
      end else if (r_r_state == R_WAIT) begin
        r_timer <= r_timer + 8'd1;
      end
      if (w_capture) begin
        r_disp <= enc_data;
      end
      if (w_timeout) begin
        r_enc_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_col <= 1'b0;
    end else if (w_mode_pulse || (r_mode_idx != c_tim_mode)) begin
      r_col <= 1'b0;
    end else if (sec_pulse) begin
      r_col <= ~r_col;
    end
  end

  assign speed_start     = r_speed_start;
  assign avg_speed_start = r_avg_start;
  assign div_select      = r_div_select;
  assign mode_idx        = r_mode_idx;
  assign enc_start       = r_enc_start;
  assign enc_mode        = r_enc_mode;
  assign disp_data       = r_disp;
  assign col             = r_col;
  assign point           = r_point;
  assign enc_err         = r_enc_err;
  assign overrun_cnt     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_display_mode_ctrl.sv
`default_nettype none
// Bench for display_mode_ctrl: directed steps plus randomized mode/blink
// traffic checked against a press/pulse counting model.
module tb_display_mode_ctrl;

  localparam int NM = 4;

  logic        clock;
  logic        reset;
  logic        mode_btn;
  logic        half_sec_pulse;
  logic        sec_pulse;
  logic [11:0] speed;
  logic        speed_valid;
  logic        avg_speed_valid;
  logic        speed_start;
  logic        avg_speed_start;
  logic        div_select;
  logic [2:0]  mode_idx;
  logic [3:0]  mode_lamp;
  logic        enc_start;
  logic [3:0]  enc_mode;
  logic        enc_valid;
  logic [47:0] enc_data;
  logic [47:0] disp_data;
  logic        col;
  logic        point;
  logic        enc_err;
  logic [7:0]  overrun_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  int          resp_lat = 3;
  logic [47:0] resp_data = 48'h0;

  display_mode_ctrl #(
    .NUM_MODES(4), .SPEED_WIDTH(12), .OVERSPEED(65), .BLINK_DIV(1),
    .TIM_MODE(2), .POINT_MASK(4'b0011), .ENC_TIMEOUT(16)
  ) dut (
    .clock(clock), .reset(reset), .mode_btn(mode_btn),
    .half_sec_pulse(half_sec_pulse), .sec_pulse(sec_pulse), .speed(speed),
    .speed_valid(speed_valid), .avg_speed_valid(avg_speed_valid),
    .speed_start(speed_start), .avg_speed_start(avg_speed_start),
    .div_select(div_select), .mode_idx(mode_idx), .mode_lamp(mode_lamp),
    .enc_start(enc_start), .enc_mode(enc_mode), .enc_valid(enc_valid),
    .enc_data(enc_data), .disp_data(disp_data), .col(col), .point(point),
    .enc_err(enc_err), .overrun_cnt(overrun_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Encoder stand-in: answers each enc_start after resp_lat cycles (0 = never)
  initial begin
    enc_valid = 1'b0;
    enc_data  = 48'h0;
    forever begin
      @(posedge clock); #1;
      enc_valid = 1'b0;
      if (enc_start && resp_lat > 0) begin
        repeat (resp_lat - 1) begin @(posedge clock); #1; end
        enc_data  = resp_data;
        enc_valid = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic press(input int hold, input int rel);
    mode_btn = 1'b1;
    step(hold);
    mode_btn = 1'b0;
    step(rel);
  endtask

  task automatic pulse_sec();
    sec_pulse = 1'b1;
    step(1);
    sec_pulse = 1'b0;
  endtask

  task automatic pulse_half();
    half_sec_pulse = 1'b1;
    step(1);
    half_sec_pulse = 1'b0;
  endtask

  task automatic pulse_spd();
    speed_valid = 1'b1;
    step(1);
    speed_valid = 1'b0;
  endtask

  task automatic pulse_avg();
    avg_speed_valid = 1'b1;
    step(1);
    avg_speed_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_mode_idx"},  64'(mode_idx),        64'(0));
    check({pfx, "_mode_lamp"}, 64'(mode_lamp),       64'(1));
    check({pfx, "_enc_mode"},  64'(enc_mode),        64'(1));
    check({pfx, "_div_sel"},   64'(div_select),      64'(1));
    check({pfx, "_spd_start"}, 64'(speed_start),     64'(0));
    check({pfx, "_avg_start"}, 64'(avg_speed_start), 64'(0));
    check({pfx, "_enc_start"}, 64'(enc_start),       64'(0));
    check({pfx, "_disp"},      64'(disp_data),       64'(0));
    check({pfx, "_col"},       64'(col),             64'(0));
    check({pfx, "_point"},     64'(point),           64'(0));
    check({pfx, "_enc_err"},   64'(enc_err),         64'(0));
    check({pfx, "_overrun"},   64'(overrun_cnt),     64'(0));
  endtask

  initial begin
    int         cnt;
    int         exp_mode;
    int         half_cnt;
    logic [3:0] pmask;
    logic [3:0] exp_lamp;
    logic [47:0] rnd_data;

    pmask           = 4'b0011;
    reset           = 1'b0;
    mode_btn        = 1'b0;
    half_sec_pulse  = 1'b0;
    sec_pulse       = 1'b0;
    speed           = 12'd0;
    speed_valid     = 1'b0;
    avg_speed_valid = 1'b0;

    // Reset state
    step(3);
    check_reset_vals("rst");
    reset = 1'b1;
    step(2);

    // Four presses held 3 cycles each: one advance and one refresh per press
    for (int k = 1; k <= 4; k++) begin
      exp_mode = k % NM;
      mode_btn = 1'b1;
      step(1);
      check("press_mode_idx", 64'(mode_idx),  64'(exp_mode));
      check("press_lamp",     64'(mode_lamp), 64'(1 << exp_mode));
      check("press_enc_start", 64'(enc_start), 64'(1));
      check("press_enc_mode", 64'(enc_mode),  64'(1 << exp_mode));
      check("press_point",    64'(point),     64'(pmask[exp_mode]));
      step(2);
      check("hold_mode_idx",  64'(mode_idx),  64'(exp_mode));
      mode_btn = 1'b0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
        step(1);
        if (enc_start) cnt++;
      end
      check("press_extra_starts", 64'(cnt), 64'(0));
    end

    // Overspeed blink, then exactly-at-threshold speed
    speed = 12'd66;
    for (int i = 1; i <= 4; i++) begin
      pulse_half();
      check("blink_lamp", 64'(mode_lamp), (i % 2 == 1) ? 64'hF : 64'h1);
    end
    speed = 12'd65;
    for (int i = 0; i < 2; i++) begin
      pulse_half();
      check("thresh_lamp", 64'(mode_lamp), 64'h1);
    end

    // Divider sequencing
    do_reset();
    speed = 12'd0;
    pulse_sec();
    check("div_spd_start", 64'(speed_start), 64'(1));
    check("div_sel_spd",   64'(div_select),  64'(1));
    step(1);
    check("div_spd_start_1cyc", 64'(speed_start), 64'(0));
    step(18);
    pulse_spd();
    check("div_avg_start", 64'(avg_speed_start), 64'(1));
    check("div_sel_avg",   64'(div_select),      64'(0));
    step(1);
    check("div_avg_start_1cyc", 64'(avg_speed_start), 64'(0));
    step(19);
    pulse_avg();
    check("div_sel_back", 64'(div_select), 64'(1));
    pulse_spd();
    check("div_ignore_spd", 64'(avg_speed_start), 64'(0));
    check("div_ignore_sel", 64'(div_select), 64'(1));

    // Overrun: three requests while busy in D_SPD
    pulse_sec();
    for (int i = 0; i < 3; i++) begin
      pulse_sec();
      step(2);
    end
    check("ovr_count", 64'(overrun_cnt), 64'(2));
    pulse_spd();
    pulse_avg();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (speed_start) cnt++;
    end
    check("ovr_pending_start", 64'(cnt), 64'(1));
    pulse_spd();
    avg_speed_valid = 1'b1;
    sec_pulse       = 1'b1;
    step(1);
    avg_speed_valid = 1'b0;
    sec_pulse       = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (speed_start) cnt++;
    end
    check("avg_done_sec_start", 64'(cnt), 64'(1));
    check("avg_done_no_ovr",    64'(overrun_cnt), 64'(2));
    pulse_spd();
    pulse_avg();

    // Encoder timeout then a normal capture
    do_reset();
    resp_lat = 0;
    pulse_sec();
    check("enc_start_sec", 64'(enc_start), 64'(1));
    step(15);
    check("enc_err_before_to", 64'(enc_err), 64'(0));
    step(1);
    check("enc_err_timeout", 64'(enc_err),   64'(1));
    check("enc_to_disp",     64'(disp_data), 64'(0));
    resp_lat  = 5;
    resp_data = 48'h3031322E3334;
    step(2);
    pulse_sec();
    step(4);
    check("enc_disp_early", 64'(disp_data), 64'(0));
    step(1);
    check("enc_disp_capture", 64'(disp_data), 64'h3031322E3334);
    check("enc_err_sticky",   64'(enc_err),   64'(1));

    // Valid arriving on the timeout cycle is accepted
    do_reset();
    rnd_data  = {$urandom(), 16'($urandom())};
    resp_data = rnd_data;
    resp_lat  = 16;
    pulse_sec();
    step(16);
    check("to_edge_disp", 64'(disp_data), 64'(rnd_data));
    check("to_edge_err",  64'(enc_err),   64'(0));

    // Colon in TIM_MODE
    do_reset();
    resp_lat = 3;
    press(1, 4);
    press(1, 4);
    check("col_mode", 64'(mode_idx), 64'(2));
    check("col_init", 64'(col),      64'(0));
    for (int i = 1; i <= 3; i++) begin
      pulse_sec();
      check("col_toggle", 64'(col), 64'(i % 2));
      step(4);
    end
    mode_btn = 1'b1;
    step(1);
    check("col_mode_change", 64'(col),      64'(0));
    check("col_mode_next",   64'(mode_idx), 64'(3));
    mode_btn = 1'b0;
    step(3);

    // Randomized presses, half-second pulses and speeds vs counting model
    do_reset();
    resp_lat = 2;
    exp_mode = 0;
    half_cnt = 0;
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          press(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
          exp_mode = (exp_mode + 1) % NM;
        end
        1: begin
          pulse_half();
          half_cnt++;
        end
        2: begin
          case ($urandom_range(0, 4))
            0: speed = 12'd64;
            1: speed = 12'd65;
            2: speed = 12'd66;
            3: speed = 12'd4095;
            default: speed = 12'($urandom_range(0, 4095));
          endcase
          step(1);
        end
        default: step(1);
      endcase
      exp_lamp = ((int'(speed) > 65) && ((half_cnt % 2) == 1)) ? 4'hF : 4'(1 << exp_mode);
      check("rnd_mode_idx", 64'(mode_idx),  64'(exp_mode));
      check("rnd_lamp",     64'(mode_lamp), 64'(exp_lamp));
    end
    step(4);
    check("rnd_no_enc_err", 64'(enc_err), 64'(0));

    // Asynchronous reset in the middle of an encoder wait
    do_reset();
    speed = 12'd0;
    press(1, 4);
    resp_lat = 0;
    pulse_sec();
    step(3);
    check("pre_rst_point", 64'(point), 64'(1));
    check("pre_rst_mode",  64'(mode_idx), 64'(1));
    reset = 1'b0;
    #1;
    check_reset_vals("async");
    step(2);
    reset = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
